block_histogram_collector: RTL
==============================

# block_histogram_collector

Consumes the raster-ordered stream of 9-bin cell histograms produced by the cell histogram stage (valid/ready) and regroups them into overlapping 2x2-cell blocks (stride one cell) for the block normalization stage. It buffers one row of cell histograms internally. It emits one 36-bin block descriptor per completed block, with block coordinates and an end-of-frame marker.

## Interface
- BIN_WIDTH, 14, width of one histogram bin (unsigned)
- IMAGE_WIDTH, 640, frame width in pixels; must be a multiple of 8 and at least 16
- IMAGE_HEIGHT, 480, frame height in pixels; must be a multiple of 8 and at least 16
- HISTOGRAM_WIDTH, BIN_WIDTH*9, width of one cell histogram
- BLOCK_WIDTH, HISTOGRAM_WIDTH*4, width of one block descriptor
- Derived constants:
  - CELLS_PER_ROW = IMAGE_WIDTH/8
  - CELL_ROWS = IMAGE_HEIGHT/8
  - COL_W = $clog2(CELLS_PER_ROW)
  - ROW_W = $clog2(CELL_ROWS)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  cell histogram valid
- in_ready  out  1  block can accept a cell histogram
- histogram  in  HISTOGRAM_WIDTH  cell histogram, bin 0 in LSBs
- out_valid  out  1  block descriptor valid
- out_ready  in  1  downstream accepts block
- block  out  BLOCK_WIDTH  {top-left, top-right, bottom-left, bottom-right} cell histograms, top-left in MSBs
- block_col  out  COL_W  block column index (0..CELLS_PER_ROW-2)
- block_row  out  ROW_W  block row index (0..CELL_ROWS-2)
- out_last  out  1  high with the final block of a frame

## Operation
- Cell counters col (0..CELLS_PER_ROW-1) and row (0..CELL_ROWS-1) track the cell being accepted.
- A cell is accepted on in_valid && in_ready.
- On acceptance:
  - col increments; on wrap it returns to 0 and row increments.
  - At (CELL_ROWS-1, CELLS_PER_ROW-1), both counters return to 0 (new frame).
- Row buffer: CELLS_PER_ROW entries of HISTOGRAM_WIDTH, indexed by col.
  - Read and write happen in the same accept cycle: the old entry at col is the top-right cell; the new histogram overwrites it.
- Registers hold top-left (previous read value) and bottom-left (previous accepted histogram).
  - Both update on every accept.
  - Their values at col==0 are don't-care; they are never emitted.
- Block formation: when the accepted cell has row>=1 and col>=1, load the output register:
  - block = {top-left, buffer[col] old value, bottom-left, histogram}
  - block_col = col-1, block_row = row-1
  - out_last = (row==CELL_ROWS-1 && col==CELLS_PER_ROW-1)
- Cells in row 0 or at col 0 are absorbed and produce no output.
- Blocks per frame: (CELLS_PER_ROW-1)*(CELL_ROWS-1); 4661 at defaults.
- Values pass unmodified; no arithmetic on bins.
- Buffer contents need no reset; an entry is always written before it is read.

## Timing
- Reset values:
  - out_valid=0, block=0, block_col=0, block_row=0, out_last=0
  - col=0, row=0
  - in_ready=1 once rst is low
- in_ready = !out_valid || out_ready (combinational). This applies to every cell, including cells that produce no block, so stream order is preserved.
- Latency: a block-completing cell accepted in cycle N gives out_valid=1 from cycle N+1.
- Output register: single entry.
  - Set when a block-completing cell is accepted.
  - Cleared on out_valid && out_ready unless a new block loads in the same cycle.
  - With simultaneous accept and load, out_valid stays 1 and the data updates. Full throughput: one block per cycle when out_ready is held high.
- out_valid && !out_ready: block, block_col, block_row and out_last hold stable; in_ready=0.
- in_valid may drop at any time; counters and registers hold.
- Frame wrap: the cell after the out_last block starts row 0 of the next frame. That cell may be accepted in the same cycle the last block is consumed.
- Reset mid-frame: the output is discarded and counters clear; the next accepted cell is cell (0,0).

## Test plan
Use IMAGE_WIDTH=32 and IMAGE_HEIGHT=24 (4x3 cells, 6 blocks) unless noted. Cell k has all bins = k.
- Full frame, out_ready=1, cells 0..11 streamed back-to-back -> exactly 6 blocks:
  - (0,0)={0,1,4,5}, (1,0)={1,2,5,6}, (2,0)={2,3,6,7}
  - (0,1)={4,5,8,9}, (1,1)={5,6,9,10}, (2,1)={6,7,10,11}
  - out_last only on the last; each block appears 1 cycle after its cell is accepted.
- Backpressure: out_ready=0 when the first block appears -> in_ready=0, outputs hold {0,1,4,5}. Raising out_ready for 1 cycle releases exactly that block, and cell 6 is accepted in the same cycle.
- Two back-to-back frames with frame 2 cells = k+100 -> frame 2 first block is {100,101,104,105} at (0,0), with no blocks mixing data from the two frames.
- Random in_valid/out_ready toggling over 3 frames -> block sequence identical to the scenario 1 reference model; no loss or duplication.
- Reset asserted after cell 6 -> out_valid=0 immediately (asynchronous). A fresh frame restarted from cell 0 gives the correct 6 blocks.
- Defaults (640x480): one frame -> 4661 blocks; final block_col=78, block_row=58, out_last=1.

Source files
------------

// File: rtl/block_histogram_collector.sv
// Regroups a raster stream of 9-bin cell histograms into overlapping 2x2-cell
// block descriptors. One row of cell histograms is kept in an internal buffer.
module block_histogram_collector #(
  parameter int unsigned BIN_WIDTH       = 14,
  parameter int unsigned IMAGE_WIDTH     = 640,
  parameter int unsigned IMAGE_HEIGHT    = 480,
  parameter int unsigned HISTOGRAM_WIDTH = BIN_WIDTH * 9,
  parameter int unsigned BLOCK_WIDTH     = HISTOGRAM_WIDTH * 4,
  localparam int unsigned CELLS_PER_ROW  = IMAGE_WIDTH / 8,
  localparam int unsigned CELL_ROWS      = IMAGE_HEIGHT / 8,
  localparam int unsigned COL_W          = $clog2(CELLS_PER_ROW),
  localparam int unsigned ROW_W          = $clog2(CELL_ROWS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [HISTOGRAM_WIDTH-1:0] histogram,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BLOCK_WIDTH-1:0]     block,
  output logic [COL_W-1:0]           block_col,
  output logic [ROW_W-1:0]           block_row,
  output logic                       out_last
);

  logic [COL_W-1:0]           col;
  logic [ROW_W-1:0]           row;
  logic [HISTOGRAM_WIDTH-1:0] row_buf [CELLS_PER_ROW];
  logic [HISTOGRAM_WIDTH-1:0] buf_rd;
  logic [HISTOGRAM_WIDTH-1:0] top_left;
  logic [HISTOGRAM_WIDTH-1:0] bottom_left;
  logic                       accept;
  logic                       col_last;
  logic                       row_last;
  logic                       make_block;

  // Handshake and block-completion decode; every cell waits on a free output slot
  always_comb begin
    in_ready   = !out_valid || out_ready;
    accept     = in_valid && in_ready;
    col_last   = (col == COL_W'(CELLS_PER_ROW - 1));
    row_last   = (row == ROW_W'(CELL_ROWS - 1));
    buf_rd     = row_buf[col];
    make_block = accept && (row != '0) && (col != '0);
  end

  // Cell position counters; wrap at end of row and end of frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Row buffer: old entry at col is read as top-right, then replaced by this cell
  always_ff @(posedge clk) begin
    if (accept) begin
      row_buf[col] <= histogram;
    end
  end

  // Left-hand cells of the next block: previous top-right and previous cell
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_left    <= '0;
      bottom_left <= '0;
    end else if (accept) begin
      top_left    <= buf_rd;
      bottom_left <= histogram;
    end
  end

  // Single-entry output register; load has priority over consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      block     <= '0;
      block_col <= '0;
      block_row <= '0;
      out_last  <= 1'b0;
    end else if (make_block) begin
      out_valid <= 1'b1;
      block     <= {top_left, buf_rd, bottom_left, histogram};
      block_col <= col - COL_W'(1);
      block_row <= row - ROW_W'(1);
      out_last  <= row_last && col_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
